// File: rtl/layer_sequencer_if.sv
// ----------------------------------------------------------------------------
// layer_sequencer_if
//   Bundles every non-clock signal between a layer_sequencer and its
//   surroundings: the configuration word stream, the sample word stream, the
//   write strobes toward the neuron layer, the layer's per-neuron output-valid
//   flags and the sequencer status flags.
//
//   Modports
//     slave  : the sequencer itself (consumes streams, drives the layer side)
//     master : whoever feeds the sequencer (host/bench) and observes it
//
//   Signals
//     start                              request a full layer configuration load
//     cfg_valid / cfg_ready / cfg_data   config word stream (weights then bias)
//     weightValid / weightValue          weight write strobe and word
//     biasValid / biasValue              bias write strobe and word
//     config_layer_num                   target layer of every write
//     config_neuron_num                  target neuron of the current write
//     s_valid / s_ready / s_data         sample word stream
//     x_valid / x_in                     sample strobe and word to the layer
//     o_valid                            per-neuron output-valid flags
//     configured / busy / done           status; done is a one-cycle pulse
// ----------------------------------------------------------------------------
interface layer_sequencer_if #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
);
    logic                 start;

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [dataWidth-1:0] cfg_data;

    logic                 weightValid;
    logic                 biasValid;
    logic [dataWidth-1:0] weightValue;
    logic [dataWidth-1:0] biasValue;
    logic [31:0]          config_layer_num;
    logic [31:0]          config_neuron_num;

    logic                 s_valid;
    logic                 s_ready;
    logic [dataWidth-1:0] s_data;

    logic                 x_valid;
    logic [dataWidth-1:0] x_in;

    logic [NN-1:0]        o_valid;

    logic                 configured;
    logic                 busy;
    logic                 done;

    modport slave (
        input  start, cfg_valid, cfg_data, s_valid, s_data, o_valid,
        output cfg_ready, weightValid, biasValid, weightValue, biasValue,
               config_layer_num, config_neuron_num, s_ready, x_valid, x_in,
               configured, busy, done
    );

    modport master (
        output start, cfg_valid, cfg_data, s_valid, s_data, o_valid,
        input  cfg_ready, weightValid, biasValid, weightValue, biasValue,
               config_layer_num, config_neuron_num, s_ready, x_valid, x_in,
               configured, busy, done
    );
endinterface

// File: rtl/layer_sequencer.sv
// ----------------------------------------------------------------------------
// layer_sequencer
//   Drives one neuron layer: on start it streams numWeight weights followed by
//   one bias into each of the NN neurons (neuron 0 first), then accepts
//   numWeight sample words per inference and waits until every neuron reports
//   a valid output before accepting the next sample set.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset (returns to IDLE, clears outputs)
//     bus  : layer_sequencer_if.slave -- streams, layer strobes and status
//
//   All layer-side strobes and data words are registered: a word accepted on
//   an edge appears on the layer side during the following cycle. Ready and
//   busy are decoded directly from the current state.
// ----------------------------------------------------------------------------
module layer_sequencer #(
    parameter int NN        = 30,
    parameter int numWeight = 784,
    parameter int dataWidth = 16,
    parameter int layerNum  = 1
) (
    input  logic             clk,
    input  logic             rst,
    layer_sequencer_if.slave bus
);
    localparam int N_W = (NN > 1) ? $clog2(NN) : 1;
    localparam int W_W = (numWeight > 1) ? $clog2(numWeight) : 1;
    localparam logic [N_W-1:0] N_LAST = N_W'(NN - 1);
    localparam logic [W_W-1:0] W_LAST = W_W'(numWeight - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_W   = 3'd1,
        LOAD_B   = 3'd2,
        RUN      = 3'd3,
        WAIT_OUT = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [N_W-1:0]       r_n;          // neuron being configured
    logic [W_W-1:0]       r_w;          // weight index within that neuron
    logic [W_W-1:0]       r_k;          // sample index within the current set

    logic                 w_cfg_ready;
    logic                 w_s_ready;
    logic                 w_busy;
    logic                 w_cfg_acc;
    logic                 w_s_acc;
    logic                 w_all_out;

    logic                 r_weight_vld;
    logic                 r_bias_vld;
    logic                 r_x_vld;
    logic                 r_done;
    logic                 r_configured;
    logic [dataWidth-1:0] r_weight_val;
    logic [dataWidth-1:0] r_bias_val;
    logic [dataWidth-1:0] r_x_in;
    logic [31:0]          r_neuron_num;

    assign w_cfg_acc = bus.cfg_valid & w_cfg_ready;
    assign w_s_acc   = bus.s_valid & w_s_ready;
    assign w_all_out = &bus.o_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = LOAD_W;
                end
            end
            LOAD_W: begin
                if (w_cfg_acc && (r_w == W_LAST)) begin
                    w_state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                if (w_cfg_acc) begin
                    w_state_nxt = (r_n == N_LAST) ? RUN : LOAD_W;
                end
            end
            RUN: begin
                // A restart request outranks finishing the sample set.
                if (bus.start) begin
                    w_state_nxt = LOAD_W;
                end else if (w_s_acc && (r_k == W_LAST)) begin
                    w_state_nxt = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (w_all_out) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_cfg_ready = 1'b0;
        w_s_ready   = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            LOAD_W, LOAD_B: begin
                w_cfg_ready = 1'b1;
                w_busy      = 1'b1;
            end
            RUN: begin
                w_s_ready = 1'b1;
            end
            WAIT_OUT: begin
                w_busy = 1'b1;
            end
            default: begin
                w_cfg_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, registered strobes and held data words
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n          <= '0;
            r_w          <= '0;
            r_k          <= '0;
            r_weight_vld <= 1'b0;
            r_bias_vld   <= 1'b0;
            r_x_vld      <= 1'b0;
            r_done       <= 1'b0;
            r_configured <= 1'b0;
            r_weight_val <= '0;
            r_bias_val   <= '0;
            r_x_in       <= '0;
            r_neuron_num <= '0;
        end else begin
            // Strobes are single-cycle; data words hold their last value.
            r_weight_vld <= 1'b0;
            r_bias_vld   <= 1'b0;
            r_x_vld      <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_n <= '0;
                        r_w <= '0;
                        r_k <= '0;
                    end
                end
                LOAD_W: begin
                    if (w_cfg_acc) begin
                        r_weight_vld <= 1'b1;
                        r_weight_val <= bus.cfg_data;
                        r_neuron_num <= 32'(r_n);
                        r_w          <= (r_w == W_LAST) ? '0 : r_w + W_W'(1);
                    end
                end
                LOAD_B: begin
                    if (w_cfg_acc) begin
                        r_bias_vld   <= 1'b1;
                        r_bias_val   <= bus.cfg_data;
                        r_neuron_num <= 32'(r_n);
                        if (r_n == N_LAST) begin
                            r_configured <= 1'b1;
                        end else begin
                            r_n <= r_n + N_W'(1);
                        end
                    end
                end
                RUN: begin
                    // A word handshaked in the same cycle as a restart is still
                    // forwarded; the restart only redirects the state.
                    if (w_s_acc) begin
                        r_x_vld <= 1'b1;
                        r_x_in  <= bus.s_data;
                        r_k     <= (r_k == W_LAST) ? '0 : r_k + W_W'(1);
                    end
                    if (bus.start) begin
                        r_n          <= '0;
                        r_w          <= '0;
                        r_k          <= '0;
                        r_configured <= 1'b0;
                    end
                end
                WAIT_OUT: begin
                    if (w_all_out) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready         = w_cfg_ready;
    assign bus.s_ready           = w_s_ready;
    assign bus.busy              = w_busy;
    assign bus.weightValid       = r_weight_vld;
    assign bus.biasValid         = r_bias_vld;
    assign bus.x_valid           = r_x_vld;
    assign bus.done              = r_done;
    assign bus.configured        = r_configured;
    assign bus.weightValue       = r_weight_val;
    assign bus.biasValue         = r_bias_val;
    assign bus.x_in              = r_x_in;
    assign bus.config_neuron_num = r_neuron_num;
    assign bus.config_layer_num  = 32'(layerNum);

endmodule

// File: tb/tb_layer_sequencer.sv
`timescale 1ns/1ps
module tb_layer_sequencer;
    localparam int NN = 2;
    localparam int NW = 3;
    localparam int DW = 16;
    localparam int LN = 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    layer_sequencer_if #(.NN(NN), .dataWidth(DW)) bus ();

    layer_sequencer #(
        .NN(NN), .numWeight(NW), .dataWidth(DW), .layerNum(LN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status packed as {weightValid, biasValid, x_valid, done,
    //                   cfg_ready, s_ready, busy, configured}
    logic [7:0]  w_stat;
    logic [79:0] w_data;
    assign w_stat = {bus.weightValid, bus.biasValid, bus.x_valid, bus.done,
                     bus.cfg_ready, bus.s_ready, bus.busy, bus.configured};
    assign w_data = {bus.weightValue, bus.biasValue, bus.x_in, bus.config_neuron_num};

    typedef struct {
        bit            st;
        bit            cv;
        logic [DW-1:0] cd;
        bit            sv;
        logic [DW-1:0] sd;
        logic [NN-1:0] ov;
        logic [7:0]    est;
        logic [DW-1:0] eval;
        int            enn;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit st, input bit cv, input logic [DW-1:0] cd,
                         input bit sv, input logic [DW-1:0] sd, input logic [NN-1:0] ov);
        bus.start     = st;
        bus.cfg_valid = cv;
        bus.cfg_data  = cd;
        bus.s_valid   = sv;
        bus.s_data    = sd;
        bus.o_valid   = ov;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input bit st, input bit cv, input logic [DW-1:0] cd,
                        input bit sv, input logic [DW-1:0] sd, input logic [NN-1:0] ov,
                        input logic [7:0] est, input logic [DW-1:0] eval, input int enn);
        vec_t v;
        v.st = st; v.cv = cv; v.cd = cd; v.sv = sv; v.sd = sd; v.ov = ov;
        v.est = est; v.eval = eval; v.enn = enn;
        vq.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    // The load is viewed as one flat stream of NN*(NW+1) words: word p goes to
    // neuron p/(NW+1) and is the bias when p%(NW+1)==NW.
    typedef enum int {M_IDLE, M_LOAD, M_RUN, M_WAIT} mode_t;
    mode_t         m_mode;
    int            m_pos;
    int            m_smp;
    bit            m_cfgd;
    bit            e_wv, e_bv, e_xv, e_done;
    logic [DW-1:0] e_wval, e_bval, e_xin;
    int            e_nn;

    task automatic model_step(input bit r, input bit st, input bit cv, input logic [DW-1:0] cd,
                              input bit sv, input logic [DW-1:0] sd, input logic [NN-1:0] ov);
        e_wv = 0; e_bv = 0; e_xv = 0; e_done = 0;
        if (r) begin
            m_mode = M_IDLE; m_pos = 0; m_smp = 0; m_cfgd = 0;
            e_wval = '0; e_bval = '0; e_xin = '0; e_nn = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (st) begin m_mode = M_LOAD; m_pos = 0; m_smp = 0; end
                M_LOAD: if (cv) begin
                    e_nn = m_pos / (NW + 1);
                    if (m_pos % (NW + 1) == NW) begin e_bv = 1; e_bval = cd; end
                    else begin e_wv = 1; e_wval = cd; end
                    m_pos++;
                    if (m_pos == NN * (NW + 1)) begin m_mode = M_RUN; m_cfgd = 1; end
                end
                M_RUN: begin
                    if (sv) begin
                        e_xv = 1; e_xin = sd; m_smp++;
                        if (m_smp == NW) begin m_smp = 0; m_mode = M_WAIT; end
                    end
                    if (st) begin m_mode = M_LOAD; m_pos = 0; m_smp = 0; m_cfgd = 0; end
                end
                M_WAIT: if (ov == {NN{1'b1}}) begin e_done = 1; m_mode = M_RUN; end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    initial begin
        int            widx;
        int            nover;
        bit            seen;
        int            typ_q[$];
        logic [DW-1:0] val_q[$];
        int            nn_q[$];
        bit            rb, stb, cvb, svb;
        logic [DW-1:0] cdv, sdv;
        logic [NN-1:0] ovv;
        logic [7:0]    est;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(0, 0, '0, 0, '0, '0);
        tick();
        tick();

        // Reset state
        chk("reset_status", 96'(w_stat), 96'(0));
        chk("reset_data", 96'(w_data), 96'(0));
        chk("layer_num", 96'(bus.config_layer_num), 96'(LN));
        rst = 1'b0;

        // Vector table: full load, sample set, output wait
        addv(1, 0, 0,  0, 0, 2'b00, 8'b0000_1010, 0,  -1);
        addv(0, 1, 1,  0, 0, 2'b00, 8'b1000_1010, 1,  0);
        addv(0, 1, 2,  0, 0, 2'b00, 8'b1000_1010, 2,  0);
        addv(0, 1, 3,  0, 0, 2'b00, 8'b1000_1010, 3,  0);
        addv(0, 1, 10, 0, 0, 2'b00, 8'b0100_1010, 10, 0);
        addv(0, 1, 4,  0, 0, 2'b00, 8'b1000_1010, 4,  1);
        addv(0, 1, 5,  0, 0, 2'b00, 8'b1000_1010, 5,  1);
        addv(0, 1, 6,  0, 0, 2'b00, 8'b1000_1010, 6,  1);
        addv(0, 1, 20, 0, 0, 2'b00, 8'b0100_0101, 20, 1);
        addv(0, 0, 0,  1, 7, 2'b00, 8'b0010_0101, 7,  -1);
        addv(0, 0, 0,  1, 8, 2'b00, 8'b0010_0101, 8,  -1);
        addv(0, 0, 0,  1, 9, 2'b00, 8'b0010_0011, 9,  -1);
        for (int i = 0; i < 5; i++) addv(0, 0, 0, 0, 0, 2'b01, 8'b0000_0011, 0, -1);
        addv(0, 0, 0,  0, 0, 2'b11, 8'b0001_0101, 0,  -1);
        addv(0, 0, 0,  0, 0, 2'b00, 8'b0000_0101, 0,  -1);

        foreach (vq[i]) begin
            drive(vq[i].st, vq[i].cv, vq[i].cd, vq[i].sv, vq[i].sd, vq[i].ov);
            tick();
            chk($sformatf("vec%0d_status", i), 96'(w_stat), 96'(vq[i].est));
            if (vq[i].est[7])
                chk($sformatf("vec%0d_weight", i), 96'({bus.weightValue, bus.config_neuron_num}),
                    96'({vq[i].eval, 32'(vq[i].enn)}));
            if (vq[i].est[6])
                chk($sformatf("vec%0d_bias", i), 96'({bus.biasValue, bus.config_neuron_num}),
                    96'({vq[i].eval, 32'(vq[i].enn)}));
            if (vq[i].est[5])
                chk($sformatf("vec%0d_x", i), 96'(bus.x_in), 96'(vq[i].eval));
        end

        // Data words hold their last values while strobes are low
        chk("hold_values", 96'({bus.weightValue, bus.biasValue, bus.x_in}),
            96'({16'd6, 16'd20, 16'd9}));

        // Start in RUN restarts the load and drops configured
        drive(1, 0, '0, 0, '0, '0);
        tick();
        chk("restart_status", 96'(w_stat), 96'(8'b0000_1010));

        // Load with cfg_valid toggling, plus an ignored start inside LOAD_W
        widx = 0; nover = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            drive(c == 3, (c % 2) == 1, 16'(100 + widx), 0, '0, '0);
            if ((c % 2) == 1) widx++;
            tick();
            if (bus.weightValid) begin typ_q.push_back(0); val_q.push_back(bus.weightValue); nn_q.push_back(int'(bus.config_neuron_num)); end
            if (bus.biasValid)   begin typ_q.push_back(1); val_q.push_back(bus.biasValue);   nn_q.push_back(int'(bus.config_neuron_num)); end
            if (32'(bus.weightValid) + 32'(bus.biasValid) + 32'(bus.x_valid) > 1) nover++;
            if (bus.configured) seen = 1;
        end
        chk("toggle_configured", 96'(seen), 96'(1));
        chk("toggle_count", 96'(typ_q.size()), 96'(8));
        chk("toggle_overlap", 96'(nover), 96'(0));
        for (int i = 0; i < 8 && i < typ_q.size(); i++)
            chk($sformatf("toggle_word%0d", i), 96'({typ_q[i], val_q[i], nn_q[i]}),
                96'({32'((i % 4) == 3), 16'(100 + i), 32'(i / 4)}));

        // Reset in the middle of a load
        drive(1, 0, '0, 0, '0, '0);
        tick();
        drive(0, 1, 16'h11, 0, '0, '0); tick();
        drive(0, 1, 16'h22, 0, '0, '0); tick();
        chk("pre_reset_weight", 96'({bus.weightValid, bus.weightValue}), 96'({1'b1, 16'h22}));
        rst = 1'b1;
        drive(0, 1, 16'h33, 0, '0, '0); tick();
        rst = 1'b0;
        chk("midload_reset_status", 96'(w_stat), 96'(0));
        chk("midload_reset_data", 96'(w_data), 96'(0));
        drive(0, 1, 16'h34, 0, '0, '0); tick();
        chk("no_load_without_start", 96'(w_stat), 96'(0));
        drive(1, 0, '0, 0, '0, '0); tick();
        drive(0, 1, 16'h44, 0, '0, '0); tick();
        chk("reload_first", 96'({bus.weightValid, bus.weightValue, bus.config_neuron_num}),
            96'({1'b1, 16'h44, 32'd0}));
        drive(0, 1, 16'h45, 0, '0, '0); tick();
        drive(0, 1, 16'h46, 0, '0, '0); tick();
        drive(0, 1, 16'h47, 0, '0, '0); tick();
        chk("reload_bias_n0", 96'({w_stat, bus.biasValue, bus.config_neuron_num}),
            96'({8'b0100_1010, 16'h47, 32'd0}));

        // Randomized run against the reference model
        rst = 1'b1;
        drive(0, 0, '0, 0, '0, '0);
        model_step(1, 0, 0, '0, 0, '0, '0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            rb  = ($urandom_range(0, 249) == 0);
            stb = ($urandom_range(0, 24) == 0);
            cvb = ($urandom_range(0, 9) < 7);
            svb = ($urandom_range(0, 9) < 7);
            cdv = 16'($urandom);
            sdv = 16'($urandom);
            ovv = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom);
            rst = rb;
            drive(stb, cvb, cdv, svb, sdv, ovv);
            model_step(rb, stb, cvb, cdv, svb, sdv, ovv);
            tick();
            est = {e_wv, e_bv, e_xv, e_done, m_mode == M_LOAD, m_mode == M_RUN,
                   (m_mode == M_LOAD) || (m_mode == M_WAIT), m_cfgd};
            chk($sformatf("rand%0d_status", c), 96'(w_stat), 96'(est));
            chk($sformatf("rand%0d_data", c), 96'(w_data), 96'({e_wval, e_bval, e_xin, 32'(e_nn)}));
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NN, default 30: neurons in the driven layer.
REQ-002 Parameter numWeight, default 784: weights per neuron and inputs per sample.
REQ-003 Parameter dataWidth, default 16: data, weight and bias word width.
REQ-004 Parameter layerNum, default 1: value driven on config_layer_num.
REQ-005 clk  in  1: single clock, rising-edge.
REQ-006 rst  in  1: synchronous, active-high reset.
REQ-007 start  in  1: one-cycle pulse that requests a full layer configuration load.
REQ-008 cfg_valid / cfg_ready  in/out  1/1: handshake for the config word stream.
REQ-009 cfg_data  in  dataWidth: config word, either a weight or a bias.
REQ-010 weightValid, biasValid  out  1/1: one-cycle write strobes to the layer.
REQ-011 weightValue, biasValue  out  dataWidth/dataWidth: registered config word.
REQ-012 config_layer_num, config_neuron_num  out  32/32: target layer and target neuron of the current write.
REQ-013 s_valid / s_ready  in/out  1/1: handshake for the sample input stream.
REQ-014 s_data  in  dataWidth: sample input word.
REQ-015 x_valid, x_in  out  1/dataWidth: registered sample word and strobe to the layer.
REQ-016 o_valid  in  NN: per-neuron output-valid flags from the layer.
REQ-017 configured, busy, done  out  1/1/1: status flags; done is a one-cycle pulse.

Function
REQ-018 FSM states: IDLE, LOAD_W, LOAD_B, RUN, WAIT_OUT.
REQ-019 IDLE→LOAD_W on start; neuron counter n=0, weight counter w=0.
REQ-020 LOAD_W: cfg_ready=1; each accepted word (cfg_valid&cfg_ready) produces weightValid=1 and weightValue=cfg_data on the next cycle, config_neuron_num=n, then w++.
REQ-021 When w=numWeight-1 is accepted in LOAD_W, next state is LOAD_B and w clears to 0.
REQ-022 LOAD_B: one accepted word produces biasValid=1 and biasValue=cfg_data on the next cycle, config_neuron_num=n.
REQ-023 After the bias in LOAD_B: if n<NN-1, n++ and next state is LOAD_W; else next state is RUN and configured goes to 1.
REQ-024 config_layer_num SHALL constantly equal layerNum.
REQ-025 cfg_ready=0 in every state other than LOAD_W/LOAD_B; no strobe is generated from an un-handshaked word.
REQ-026 RUN: s_ready=1; each accepted word gives x_valid=1 and x_in=s_data one cycle later; sample counter k++.
REQ-027 When k=numWeight-1 is accepted in RUN, next state is WAIT_OUT, k clears to 0, s_ready=0.
REQ-028 WAIT_OUT→RUN when &o_valid=1; done=1 for exactly that one cycle.
REQ-029 start in RUN: restart the load at LOAD_W with n=w=0 and configured=0.
REQ-030 start in LOAD_W, LOAD_B or WAIT_OUT is ignored.
REQ-031 busy=1 in LOAD_W, LOAD_B and WAIT_OUT; busy=0 in IDLE and RUN.
REQ-032 Strobes SHALL never overlap: at most one of weightValid, biasValid and x_valid is high in any cycle.
REQ-033 Data outputs hold their last value when the corresponding strobe is low.
REQ-034 Counter widths are $clog2 of each bound (min 1); counters never exceed their bound; there is no wrap-around.

Reset
REQ-035 On rst=1 at a clock edge: state=IDLE, counters=0, and all strobes, ready, configured, busy, done and data outputs =0, including when reset arrives mid-load or mid-sample.
REQ-036 After reset, a new start is required; all partial configuration is discarded.

Verification (NN=2, numWeight=3, dataWidth=16)
REQ-037 start, then cfg words 1,2,3,10,4,5,6,20 with cfg_valid held high → weightValid pulses with values 1,2,3 (neuron 0), biasValid with 10, then 4,5,6 (neuron 1) and bias 20; configured=1 after the last bias.
REQ-038 cfg_valid toggled every other cycle during load → exactly 8 strobes, values in order, no duplicates.
REQ-039 Configured; s_data 7,8,9 → x_valid pulses 7,8,9; s_ready=0 after the third; o_valid=2'b01 for 5 cycles with no done, then 2'b11 → one done pulse and return to RUN.
REQ-040 rst asserted after the 2nd weight → all outputs 0 next cycle; the next start reloads from neuron 0, weight 0.
REQ-041 start during LOAD_W → ignored, sequence unchanged; start in RUN → configured=0 and the reload begins at neuron 0.
